bus_mux_arbiter: RTL and testbench

Parametrised, registered successor to the core's source-select data mux. It selects one of NSRC source buses onto a single WIDTH-bit output register, feeding the shared core data bus. Selection is either by explicit select code (mode 0) or by round-robin arbitration among requesting sources (mode 1). The output stage uses a valid/ready handshake with backpressure and returns a one-cycle acknowledge to the captured source.

---
 rtl/bus_mux_arbiter.sv | 124 ++++++++++++
 tb/tb_bus_mux_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_mux_arbiter.sv
// Registered source-select mux for the shared core data bus: explicit select (mode 0)
// or round-robin arbitration (mode 1), valid/ready output stage, one-cycle source acknowledge.
module bus_mux_arbiter #(
  parameter int WIDTH = 16,
  parameter int NSRC  = 16,
  parameter int SELW  = $clog2(NSRC)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic [SELW-1:0]       sel,
  input  logic                  sel_valid,
  input  logic [NSRC-1:0]       src_req,
  input  logic [NSRC*WIDTH-1:0] src_data,
  output logic [NSRC-1:0]       src_ack,
  output logic [WIDTH-1:0]      out_data,
  output logic [SELW-1:0]       out_src,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sel_err
);

  localparam logic [SELW:0]     NSRC_W     = (SELW+1)'(NSRC);
  localparam logic [SELW-1:0]   PTR_RESET  = SELW'(NSRC - 1);
  localparam logic [NSRC-1:0]   ONE_HOT_LSB = {{(NSRC-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] src_word_s [NSRC];
  logic             sel_in_range_s;
  logic             sel_ok_s;
  logic             sel_err_s;
  logic             rr_found_s;
  logic [SELW-1:0]  rr_idx_s;
  logic             slot_free_s;
  logic             cap_req_s;
  logic [SELW-1:0]  cap_idx_s;
  logic             capture_s;

  logic [WIDTH-1:0] out_data_r;
  logic [SELW-1:0]  out_src_r;
  logic             out_valid_r;
  logic [NSRC-1:0]  src_ack_r;
  logic             sel_err_r;
  logic [SELW-1:0]  ptr_r;

  for (genvar i = 0; i < NSRC; i++) begin : g_unpack
    assign src_word_s[i] = src_data[i*WIDTH +: WIDTH];
  end

  assign sel_in_range_s = ({1'b0, sel} < NSRC_W);
  assign sel_ok_s       = sel_valid && sel_in_range_s;
  assign sel_err_s      = (mode == 1'b0) && sel_valid && !sel_in_range_s;
  assign slot_free_s    = !out_valid_r || out_ready;

  // Round-robin search: first requester at or after ptr+1, wrapping modulo NSRC.
  always_comb begin
    logic [SELW:0] cand_raw_v;
    logic [SELW:0] cand_v;
    rr_found_s = 1'b0;
    rr_idx_s   = '0;
    cand_raw_v = '0;
    cand_v     = '0;
    for (int k = 0; k < NSRC; k++) begin
      cand_raw_v = {1'b0, ptr_r} + (SELW+1)'(k + 1);
      cand_v     = (cand_raw_v >= NSRC_W) ? (cand_raw_v - NSRC_W) : cand_raw_v;
      if (!rr_found_s && src_req[cand_v[SELW-1:0]]) begin
        rr_found_s = 1'b1;
        rr_idx_s   = cand_v[SELW-1:0];
      end else begin
        rr_found_s = rr_found_s;
      end
    end
  end

  // Mode-dependent capture request and source index.
  always_comb begin
    cap_req_s = 1'b0;
    cap_idx_s = '0;
    if (mode) begin
      cap_req_s = rr_found_s;
      cap_idx_s = rr_idx_s;
    end else begin
      cap_req_s = sel_ok_s;
      cap_idx_s = sel;
    end
  end

  assign capture_s = slot_free_s && cap_req_s;

  // Output register, acknowledge pulse and fairness pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_r  <= '0;
      out_src_r   <= '0;
      out_valid_r <= 1'b0;
      src_ack_r   <= '0;
      sel_err_r   <= 1'b0;
      ptr_r       <= PTR_RESET;
    end else begin
      sel_err_r <= sel_err_s;
      if (capture_s) begin
        out_data_r  <= src_word_s[cap_idx_s];
        out_src_r   <= cap_idx_s;
        out_valid_r <= 1'b1;
        src_ack_r   <= ONE_HOT_LSB << cap_idx_s;
        ptr_r       <= cap_idx_s;
      end else begin
        src_ack_r <= '0;
        // A consumed word with nothing to replace it leaves the slot empty.
        if (out_ready) begin
          out_valid_r <= 1'b0;
        end else begin
          out_valid_r <= out_valid_r;
        end
      end
    end
  end

  assign out_data  = out_data_r;
  assign out_src   = out_src_r;
  assign out_valid = out_valid_r;
  assign src_ack   = src_ack_r;
  assign sel_err   = sel_err_r;

endmodule

// File: tb/tb_bus_mux_arbiter.sv
// Scoreboard bench for bus_mux_arbiter (WIDTH 16, NSRC 12): directed scenarios plus
// randomized traffic checked against a queue-fed behavioural model.
module tb_bus_mux_arbiter;

  localparam int W  = 16;
  localparam int N  = 12;
  localparam int SW = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             mode;
  logic [SW-1:0]    sel;
  logic             sel_valid;
  logic [N-1:0]     src_req;
  logic [N*W-1:0]   src_data;
  logic [N-1:0]     src_ack;
  logic [W-1:0]     out_data;
  logic [SW-1:0]    out_src;
  logic             out_valid;
  logic             out_ready;
  logic             sel_err;

  bus_mux_arbiter #(.WIDTH(W), .NSRC(N), .SELW(SW)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .sel_valid(sel_valid),
    .src_req(src_req), .src_data(src_data), .src_ack(src_ack),
    .out_data(out_data), .out_src(out_src), .out_valid(out_valid),
    .out_ready(out_ready), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           valid;
    logic [W-1:0] data;
    int           src;
    logic [N-1:0] ack;
    bit           err;
  } exp_t;

  exp_t q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: the word in the slot and the index of the last grant.
  bit           m_valid;
  logic [W-1:0] m_data;
  int           m_src;
  int           m_ptr;
  bit           fixed_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_src   = 0;
    m_ptr   = N - 1;
  endtask

  // Apply one cycle of stimulus, predict the post-edge outputs, then advance to the next negedge.
  task automatic drive(input bit md, input int s, input bit sv, input logic [N-1:0] req, input bit rdy);
    exp_t e;
    int   win;
    int   idx;
    bit   free;
    src_data = '0;
    for (int i = 0; i < N; i++) begin
      if (fixed_data) src_data = src_data | ((N*W)'(16'h1000 + i) << (i*W));
      else            src_data = src_data | ((N*W)'($urandom_range(0, 65535)) << (i*W));
    end
    mode = md; sel = SW'(s); sel_valid = sv; src_req = req; out_ready = rdy;
    free = !m_valid || rdy;
    win  = -1;
    if (!md) begin
      if (sv && s < N) win = s;
    end else begin
      for (int k = 1; k <= N; k++) begin
        idx = (m_ptr + k) % N;
        if (win < 0 && req[SW'(idx)]) win = idx;
      end
    end
    e.err = !md && sv && (s >= N);
    e.ack = '0;
    if (free && win >= 0) begin
      m_valid = 1'b1;
      m_data  = W'(src_data >> (win*W));
      m_src   = win;
      m_ptr   = win;
      e.ack   = {{(N-1){1'b0}}, 1'b1} << win;
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    e.valid = m_valid;
    e.data  = m_data;
    e.src   = m_src;
    q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: compare every presented cycle against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("mon_valid", 64'(out_valid), 64'(e.valid));
        check("mon_ack",   64'(src_ack),   64'(e.ack));
        check("mon_err",   64'(sel_err),   64'(e.err));
        if (e.valid) begin
          check("mon_data", 64'(out_data), 64'(e.data));
          check("mon_src",  64'(out_src),  64'(e.src));
        end
      end
    end
  end

  initial begin
    int           got[13];
    logic [W-1:0] held_data;
    logic [SW-1:0] held_src;
    logic [N-1:0] req_v;

    rst = 1'b1; mode = 1'b0; sel = '0; sel_valid = 1'b0; src_req = '0;
    src_data = '0; out_ready = 1'b0; fixed_data = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_data",  64'(out_data),  64'(0));
    check("rst_src",   64'(out_src),   64'(0));
    check("rst_ack",   64'(src_ack),   64'(0));
    check("rst_err",   64'(sel_err),   64'(0));
    rst = 1'b0;

    repeat (3) drive(1'b1, 0, 1'b0, '0, 1'b1);

    // Explicit select of source 5.
    drive(1'b0, 5, 1'b1, '0, 1'b1);
    check("m0_data", 64'(out_data), 64'(16'h1005));
    check("m0_src",  64'(out_src),  64'(5));
    check("m0_ack",  64'(src_ack),  64'(12'h020));

    // Out-of-range select while the word is held.
    drive(1'b0, 13, 1'b1, '0, 1'b0);
    check("bad_err",   64'(sel_err),   64'(1));
    check("bad_ack",   64'(src_ack),   64'(0));
    check("bad_valid", 64'(out_valid), 64'(1));
    check("bad_data",  64'(out_data),  64'(16'h1005));
    drive(1'b1, 0, 1'b0, '0, 1'b1);

    // Asynchronous reset with a held word.
    drive(1'b0, 7, 1'b1, '0, 1'b0);
    check("pre_rst_valid", 64'(out_valid), 64'(1));
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 64'(out_valid), 64'(0));
    check("arst_data",  64'(out_data),  64'(0));
    check("arst_src",   64'(out_src),   64'(0));
    check("arst_ack",   64'(src_ack),   64'(0));
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 0, 1'b0, '0, 1'b1);
    check("post_rst_idle", 64'(out_valid), 64'(0));

    // Round-robin sweep with every source requesting.
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, 0, 1'b0, 12'hFFF, 1'b1);
      got[i] = int'(out_src);
    end
    for (int i = 0; i < 13; i++) check("rr_sweep", 64'(got[i]), 64'(i % N));

    // Backpressure: frozen output, no acks, then capture without a bubble.
    held_data = out_data;
    held_src  = out_src;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 0, 1'b0, 12'hFFF, 1'b0);
      check("bp_data", 64'(out_data), 64'(held_data));
      check("bp_src",  64'(out_src),  64'(held_src));
      check("bp_ack",  64'(src_ack),  64'(0));
    end
    drive(1'b1, 0, 1'b0, 12'hFFF, 1'b1);
    check("bp_resume_src",   64'(out_src),   64'(1));
    check("bp_resume_ack",   64'(src_ack),   64'(12'h002));
    check("bp_resume_valid", 64'(out_valid), 64'(1));

    // Sparse requests from ptr = 0, then a mode switch.
    drive(1'b0, 0, 1'b1, '0, 1'b1);
    drive(1'b1, 0, 1'b0, 12'h801, 1'b1);
    check("sparse_g0", 64'(out_src), 64'(11));
    drive(1'b1, 0, 1'b0, 12'h801, 1'b1);
    check("sparse_g1", 64'(out_src), 64'(0));
    drive(1'b1, 0, 1'b0, 12'h801, 1'b1);
    check("sparse_g2", 64'(out_src), 64'(11));
    drive(1'b0, 3, 1'b1, '0, 1'b1);
    check("switch_m0", 64'(out_src), 64'(3));
    drive(1'b1, 0, 1'b0, 12'hFFF, 1'b1);
    check("switch_rr", 64'(out_src), 64'(4));

    // Randomized traffic.
    fixed_data = 1'b0;
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0:       req_v = '0;
        1:       req_v = {{(N-1){1'b0}}, 1'b1} << $urandom_range(0, N-1);
        default: req_v = N'($urandom);
      endcase
      drive(1'(($urandom_range(0, 1))), int'($urandom_range(0, 15)),
            1'(($urandom_range(0, 3) != 0)), req_v,
            1'(($urandom_range(0, 9) < 7)));
    end

    repeat (2) @(negedge clk);
    check("queue_drained", 64'(q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
